// File: rtl/snow3g_pkg.sv
// SNOW 3G S1 shared definitions.
// Reduction constant, MULx and the AES SR table.
package snow3g_pkg;

  localparam logic [7:0] RED_POLY = 8'h1B;

  localparam logic [0:255][7:0] SR_TABLE = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] mulx(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? RED_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/snow3g_sr_sbox.sv
// AES SR S-box: combinational byte lookup.
module snow3g_sr_sbox
  import snow3g_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = SR_TABLE[x];

endmodule

// File: rtl/snow3g_s1.sv
// SNOW 3G S1: four SR lookups, GF(2^8) column mix,
// registered 32-bit result.
module snow3g_s1
  import snow3g_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] w,
  output logic [31:0] s1_out
);

  logic [7:0] s  [4];
  logic [7:0] m2 [4];
  logic [7:0] m3 [4];
  logic [31:0] r;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    snow3g_sr_sbox u_sr (
      .x (w[31-8*i -: 8]),
      .y (s[i])
    );
    assign m2[i] = mulx(s[i]);
    assign m3[i] = m2[i] ^ s[i];
  end

  always_comb begin
    r = '0;
    r[31:24] = m2[0] ^ s[1]  ^ s[2]  ^ m3[3];
    r[23:16] = m3[0] ^ m2[1] ^ s[2]  ^ s[3];
    r[15:8]  = s[0]  ^ m3[1] ^ m2[2] ^ s[3];
    r[7:0]   = s[0]  ^ s[1]  ^ m3[2] ^ m2[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_out <= '0;
    else        s1_out <= r;
  end

endmodule

// File: tb/tb_snow3g_s1.sv
// Self-checking bench for snow3g_s1.
// Reference S-box derived from GF inverse + affine map.
module tb_snow3g_s1;

  logic        clk;
  logic        rst_n;
  logic [31:0] w;
  logic [31:0] s1_out;

  int n_tests;
  int n_fail;

  snow3g_s1 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .w      (w),
    .s1_out (s1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v,
                                      input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sr(input logic [7:0] v);
    logic [7:0] inv;
    logic [7:0] b;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, v);
    if (v == 8'h00) inv = 8'h00;
    b = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
        ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    return b;
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] v);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] q0, q1, q2, q3;
    a0 = ref_sr(v[31:24]);
    a1 = ref_sr(v[23:16]);
    a2 = ref_sr(v[15:8]);
    a3 = ref_sr(v[7:0]);
    q0 = gmul(8'h02, a0) ^ a1 ^ a2 ^ gmul(8'h03, a3);
    q1 = gmul(8'h03, a0) ^ gmul(8'h02, a1) ^ a2 ^ a3;
    q2 = a0 ^ gmul(8'h03, a1) ^ gmul(8'h02, a2) ^ a3;
    q3 = a0 ^ a1 ^ gmul(8'h03, a2) ^ gmul(8'h02, a3);
    return {q0, q1, q2, q3};
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] w;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] rv;
    logic [31:0] ea;
    logic [31:0] eb;

    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{"zero",    32'h00000000, 32'h63636363};
    vecs[1] = '{"uniform01", 32'h01010101, 32'h7C7C7C7C};
    vecs[2] = '{"mix9f",   32'h9F825068, 32'h22460DB7};
    vecs[3] = '{"uniformff", 32'hFFFFFFFF, 32'h16161616};
    vecs[4] = '{"uniform52", 32'h52525252, 32'h00000000};
    vecs[5] = '{"uniform9f", 32'h9F9F9F9F, 32'hDBDBDBDB};

    rst_n = 1'b0;
    w     = 32'h00000000;
    #2;
    check("reset_initial", s1_out, 32'h00000000);
    step();
    step();
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      w = vecs[i].w;
      step();
      check(vecs[i].name, s1_out, vecs[i].exp);
    end

    ea = ref_s1(32'hE19FCF13);
    eb = ref_s1(32'h084B14B4);

    // mid-cycle input change must not show before the edge
    w = 32'hE19FCF13;
    #2;
    check("no_early_update", s1_out, vecs[5].exp);
    step();
    check("b2b_first", s1_out, ea);
    w = 32'h084B14B4;
    #2;
    check("b2b_hold", s1_out, ea);
    step();
    check("b2b_second", s1_out, eb);

    w = 32'hE19FCF13;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", s1_out, 32'h00000000);
    step();
    check("reset_held1", s1_out, 32'h00000000);
    step();
    check("reset_held2", s1_out, 32'h00000000);
    #2;
    rst_n = 1'b1;
    #1;
    check("reset_release_wait", s1_out, 32'h00000000);
    step();
    check("reset_release_load", s1_out, ea);

    for (int i = 0; i < 10000; i++) begin
      rv = $urandom;
      if (i % 4 == 0) rv = rv | 32'h80808080;
      w = rv;
      step();
      check("random", s1_out, ref_s1(rv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
